// File: rtl/disp_pkg.sv
// Shared types and default parameter values for the multiplexed display scanner.
//   scan_state_t : two-state scan FSM (GUARD = all digits dark, ON = current digit lit)
//   digit_t      : one register-file entry, 4-bit decoder code plus blank flag
package disp_pkg;

  localparam int unsigned NDIG_DFLT      = 4;
  localparam int unsigned SLOT_CYC_DFLT  = 50000;
  localparam int unsigned GUARD_CYC_DFLT = 500;
  localparam int unsigned BLINK_CYC_DFLT = 12500000;

  typedef enum logic {
    GUARD,
    ON
  } scan_state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
  } digit_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: emits a one-cycle tick every N clock cycles.
//   clk   : clock
//   reset : synchronous active-high reset, restarts the count at zero
//   tick  : high on the last cycle of every N-cycle period
module tick_gen #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with per-digit blank and blink.
//   clk, reset : single clock, synchronous active-high reset
//   wr_en      : one-cycle write strobe into the digit register file
//   wr_addr    : digit index to write (indices >= NDIG are dropped)
//   wr_val     : decoder value code for that digit
//   wr_blank   : 1 blanks the written digit
//   blink_mask : per-digit blink enable, sampled every cycle
//   num        : registered value code for the segment decoder, held per slot
//   digit_sel  : registered one-hot digit enable, all zero while dark
//   slot_done  : one-cycle pulse on the final cycle of each slot
// Each slot is GUARD_CYC dark cycles followed by SLOT_CYC-GUARD_CYC lit cycles.
// GUARD_CYC must be at least 1 and less than SLOT_CYC.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned NDIG      = NDIG_DFLT,
  parameter int unsigned SLOT_CYC  = SLOT_CYC_DFLT,
  parameter int unsigned GUARD_CYC = GUARD_CYC_DFLT,
  parameter int unsigned BLINK_CYC = BLINK_CYC_DFLT,
  localparam int unsigned AW       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [3:0]      wr_val,
  input  logic            wr_blank,
  input  logic [NDIG-1:0] blink_mask,
  output logic [3:0]      num,
  output logic [NDIG-1:0] digit_sel,
  output logic            slot_done
);

  localparam int unsigned CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(SLOT_CYC - GUARD_CYC - 1);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          slot_end;

  digit_t        entries_q [NDIG];
  logic          wr_ok;

  logic          blink_tick;
  logic          phase_q, phase_d;

  digit_t        lat_q, lat_d;
  logic [NDIG-1:0] digit_sel_q, digit_sel_d;
  logic          slot_done_q, slot_done_d;
  logic          lit;

  assign wr_ok = (32'(wr_addr) < NDIG);

  // Register file
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) begin
        entries_q[i] <= '{value: 4'h0, blank: 1'b1};
      end
    end else if (wr_en && wr_ok) begin
      entries_q[wr_addr] <= '{value: wr_val, blank: wr_blank};
    end
  end

  // Blink phase, free-running and unrelated to the scan
  tick_gen #(
    .N (BLINK_CYC)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .tick  (blink_tick)
  );

  assign phase_d = blink_tick ? ~phase_q : phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Scan FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GUARD;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Scan FSM: next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    slot_end = 1'b0;
    unique case (state_q)
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        if (cnt_q == ON_LAST) begin
          state_d  = GUARD;
          cnt_d    = '0;
          slot_end = 1'b1;
          idx_d    = (idx_q == AW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase
  end

  // Scan FSM: outputs, computed from next state so the registered outputs line up with state_q
  always_comb begin
    lat_d = lat_q;
    if (slot_end) begin
      // Write-first: a write landing on the boundary edge is what the new slot shows
      if (wr_en && wr_ok && (wr_addr == idx_d)) begin
        lat_d = '{value: wr_val, blank: wr_blank};
      end else begin
        lat_d = entries_q[idx_d];
      end
    end
    lit = (state_d == ON) && !lat_d.blank && !(blink_mask[idx_d] && !phase_d);
    digit_sel_d        = '0;
    digit_sel_d[idx_d] = lit;
    slot_done_d = (state_d == ON) && (cnt_d == ON_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_q       <= '{value: 4'h0, blank: 1'b1};
      digit_sel_q <= '0;
      slot_done_q <= 1'b0;
    end else begin
      lat_q       <= lat_d;
      digit_sel_q <= digit_sel_d;
      slot_done_q <= slot_done_d;
    end
  end

  assign num       = lat_q.value;
  assign digit_sel = digit_sel_q;
  assign slot_done = slot_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with a per-cycle scoreboard.
// Expected outputs come from an arithmetic model keyed on cycles since reset.
module tb_disp_scan_ctrl;

  localparam int unsigned NDIG      = 4;
  localparam int unsigned SLOT_CYC  = 8;
  localparam int unsigned GUARD_CYC = 2;
  localparam int unsigned BLINK_CYC = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_val = 4'h0;
  logic       wr_blank = 1'b0;
  logic [3:0] blink_mask = 4'h0;
  logic [3:0] num;
  logic [3:0] digit_sel;
  logic       slot_done;

  disp_scan_ctrl #(
    .NDIG      (NDIG),
    .SLOT_CYC  (SLOT_CYC),
    .GUARD_CYC (GUARD_CYC),
    .BLINK_CYC (BLINK_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_val     (wr_val),
    .wr_blank   (wr_blank),
    .blink_mask (blink_mask),
    .num        (num),
    .digit_sel  (digit_sel),
    .slot_done  (slot_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] num;
    logic [3:0] sel;
    logic       done;
  } exp_t;

  exp_t sb[$];

  // Model state: cycles since the last reset edge, digit contents, slot latch
  int         t = 0;
  logic [3:0] m_val [4];
  logic       m_blank [4];
  logic [3:0] lat_val = 4'h0;
  logic       lat_blank = 1'b1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, clock once, then pop and compare.
  task automatic cycle();
    exp_t e;
    int   pos;
    int   idx;
    bit   phase;
    if (reset) begin
      t = 0;
      for (int i = 0; i < 4; i++) begin
        m_val[i]   = 4'h0;
        m_blank[i] = 1'b1;
      end
      lat_val   = 4'h0;
      lat_blank = 1'b1;
      e = '{num: 4'h0, sel: 4'h0, done: 1'b0};
    end else begin
      t++;
      pos = t % SLOT_CYC;
      idx = (t / SLOT_CYC) % NDIG;
      if (pos == 0) begin
        if (wr_en && (int'(wr_addr) == idx)) begin
          lat_val   = wr_val;
          lat_blank = wr_blank;
        end else begin
          lat_val   = m_val[idx];
          lat_blank = m_blank[idx];
        end
      end
      if (wr_en) begin
        m_val[wr_addr]   = wr_val;
        m_blank[wr_addr] = wr_blank;
      end
      phase = ((t / BLINK_CYC) % 2) == 0;
      e.num  = lat_val;
      e.sel  = (pos >= GUARD_CYC && !lat_blank && !(blink_mask[idx] && !phase)) ?
               4'(1 << idx) : 4'h0;
      e.done = (pos == SLOT_CYC - 1);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("num", num, e.num);
    chk("digit_sel", digit_sel, e.sel);
    chk("slot_done", {3'b000, slot_done}, {3'b000, e.done});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the current cycle is slot index idx at position pos.
  task automatic run_until(input int idx, input int pos);
    int n = 0;
    while (!(((t / SLOT_CYC) % NDIG) == idx && (t % SLOT_CYC) == pos) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL run_until idx=%0d pos=%0d not reached", idx, pos);
    end
  endtask

  task automatic write(input logic [1:0] a, input logic [3:0] v, input logic b);
    wr_en    = 1'b1;
    wr_addr  = a;
    wr_val   = v;
    wr_blank = b;
    cycle();
    wr_en    = 1'b0;
  endtask

  // Continuous output-shape checks once the DUT has been reset
  bit         armed = 1'b0;
  logic [3:0] prev_num;

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      assert ($onehot0(digit_sel)) else begin
        errors++;
        $error("FAIL onehot0 observed=%b expected=onehot0", digit_sel);
      end
      if (num !== prev_num) begin
        checks++;
        assert (digit_sel === 4'h0) else begin
          errors++;
          $error("FAIL sel_on_num_change observed=%b expected=0000", digit_sel);
        end
      end
    end
    prev_num <= num;
  end

  initial begin
    // Reset, then idle: everything blanked, slot_done every 8 cycles
    run(2);
    reset = 1'b0;
    armed = 1'b1;
    run(40);

    // Fill digits 0-3 with 1..4 and scan them
    write(2'd0, 4'd1, 1'b0);
    write(2'd1, 4'd2, 1'b0);
    write(2'd2, 4'd3, 1'b0);
    write(2'd3, 4'd4, 1'b0);
    run_until(0, 2);
    chk("d0_num", num, 4'd1);
    chk("d0_sel", digit_sel, 4'b0001);
    run_until(3, 7);
    chk("d3_sel", digit_sel, 4'b1000);
    cycle();
    chk("wrap_guard_sel", digit_sel, 4'b0000);
    run(40);

    // Mid-slot write to the displayed digit is deferred to its next slot
    run_until(1, 4);
    write(2'd1, 4'd9, 1'b0);
    chk("midslot_num_held", num, 4'd2);
    run_until(1, 2);
    chk("next_slot_num", num, 4'd9);
    chk("next_slot_sel", digit_sel, 4'b0010);

    // Write on the boundary edge into the incoming digit shows at once
    run_until(1, 7);
    write(2'd2, 4'd9, 1'b0);
    chk("boundary_num", num, 4'd9);
    run(16);

    // Blink digit 2 only
    blink_mask = 4'b0100;
    run(256);
    blink_mask = 4'b0000;
    run(16);

    // Reset during digit 2's ON phase
    run_until(2, 4);
    reset = 1'b1;
    cycle();
    chk("rst_num", num, 4'd0);
    chk("rst_sel", digit_sel, 4'b0000);
    reset = 1'b0;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NDIG, 4, number of multiplexed 7-segment digits.
- SLOT_CYC, 50000, clock cycles per digit slot (guard plus on time).
- GUARD_CYC, 500, cycles at the start of each slot with all digits off; must be less than SLOT_CYC.
- BLINK_CYC, 12500000, cycles per blink half-period.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- wr_en, in, 1, write strobe for one cycle.
- wr_addr, in, clog2(NDIG), digit index to write.
- wr_val, in, 4, value code for the digit (0-15, the decoder's input code).
- wr_blank, in, 1, 1 marks the written digit as blanked.
- blink_mask, in, NDIG, a set bit makes that digit blink.
- num, out, 4, value code driven to the segment decoder.
- digit_sel, out, NDIG, one-hot active-high digit enable; all zero means no digit lit.
- slot_done, out, 1, one-cycle pulse on the last cycle of each slot.
REQ-003 Clocking and reset SHALL be: one clock (clk); reset is synchronous and active-high.

Function
REQ-004 Register file: the block SHALL hold NDIG entries, each a 4-bit value plus a blank flag.
REQ-005 Writes: wr_en=1 SHALL update entry wr_addr at the next clk edge.
- There is no backpressure; every write is accepted.
- wr_addr >= NDIG SHALL be ignored.
REQ-006 Scan FSM: the controller SHALL have two states, GUARD and ON.
- GUARD lasts GUARD_CYC cycles, then the FSM goes to ON.
- ON lasts SLOT_CYC-GUARD_CYC cycles, then the FSM goes to GUARD and the digit index advances.
REQ-007 Index wrap: the digit index SHALL advance from NDIG-1 to 0.
REQ-008 Value latch: on entry to GUARD, num SHALL latch the value of the new index's entry.
- num is held constant for the whole slot.
- A write to the digit currently displayed SHALL only appear on that digit's next slot.
REQ-009 Digit select in GUARD: digit_sel SHALL be all zero.
REQ-010 Digit select in ON: digit_sel SHALL be one-hot at the current index, unless the digit is suppressed.
- A digit is suppressed if its latched blank flag is 1.
- A digit is also suppressed if its blink_mask bit is 1 and blink_phase is 0.
- A suppressed digit gives digit_sel all zero.
REQ-011 Blink: blink_phase SHALL toggle every BLINK_CYC cycles, free-running and independent of the scan.
- blink_mask SHALL be sampled every cycle.
REQ-012 slot_done SHALL pulse for exactly one cycle, on the final ON cycle of every slot.
REQ-013 Simultaneous events: a write in the same cycle as a slot boundary SHALL be visible in num if it targets the new index.
- The latch path uses write-bypass (write-first).
REQ-014 Outputs num and digit_sel SHALL be registered with no combinational path from any input.
REQ-015 Output timing: digit_sel SHALL never be nonzero in the cycle num changes.

Reset
REQ-016 reset=1 SHALL force the following at the next edge, regardless of the current state:
- All entries: value 0, blank 1.
- State GUARD with a zeroed slot counter.
- Digit index 0.
- blink_phase 1 and blink counter 0.
- num 0, digit_sel 0, slot_done 0.
REQ-017 Reset mid-slot SHALL abandon the slot.
- The first post-reset slot is index 0 with a full GUARD.

Structure
REQ-018 Package disp_pkg SHALL hold the following:
- State enum {GUARD, ON}.
- Default values for NDIG, SLOT_CYC, GUARD_CYC and BLINK_CYC.
- Typedef digit_t, a struct of a 4-bit value and a blank bit.
REQ-019 Sub-module: the blink divider SHALL be a separate sub-module tick_gen (parameter N, output a one-cycle tick every N cycles).
- The scan counter is kept inline.
REQ-020 The output num SHALL drive the existing segment decoder directly; this block contains no segment encoding.

Verification (bench parameters: NDIG=4, SLOT_CYC=8, GUARD_CYC=2, BLINK_CYC=64)
REQ-021 Reset then idle 40 cycles -> digit_sel=0 throughout, because all entries are blanked; slot_done pulses every 8 cycles.
REQ-022 Write 1,2,3,4 to digits 0-3 with blank=0 -> in each slot, num matches the digit's value, digit_sel is 0001/0010/0100/1000 for 6 cycles after 2 guard cycles, and the index wraps back to 0001.
REQ-023 Write 9 to digit 1 mid-way through digit 1's ON phase -> num stays 2 for the current slot and shows 9 on the next digit-1 slot; the write at the boundary shows 9 immediately.
REQ-024 blink_mask=0100 -> digit 2 is lit only during blink_phase=1 windows (64 cycles on, 64 off); the other digits are unaffected.
REQ-025 Assert reset during digit 2's ON phase -> next cycle num=0 and digit_sel=0; the scan restarts at index 0 with a full 2-cycle guard and all digits are blanked.
REQ-026 Assertion, checked continuously: $onehot0(digit_sel), and digit_sel=0 in any cycle where num changed.
